// File: rtl/pipe_branch_predictor_if.sv
// Signal bundle between the pipeline (master) and the branch predictor (slave).
// The IF-side prediction signals and the EX-side resolution signals share this one bundle.
interface pipe_branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
   logic [XLEN-1:0]  if_pc;
   logic             pred_taken;
   logic [XLEN-1:0]  pred_target;
   logic             ex_branch_en;
   logic [2:0]       ex_func3;
   logic [XLEN-1:0]  ex_rs1;
   logic [XLEN-1:0]  ex_rs2;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_target;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic             ex_taken;
   logic             ex_mispredict;
   logic [XLEN-1:0]  ex_redirect_pc;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output if_pc, ex_branch_en, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_target,
             ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, ex_taken, ex_mispredict, ex_redirect_pc,
             mispredict_cnt
   );

   modport slave (
      input  if_pc, ex_branch_en, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_target,
             ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, ex_taken, ex_mispredict, ex_redirect_pc,
             mispredict_cnt
   );
endinterface

// File: rtl/pipe_branch_predictor.sv
// Branch predictor for the pipelined OTTER. The IF stage looks up a BHT of 2-bit counters and a direct-mapped BTB.
// The EX stage resolves the branch, requests a redirect on a mispredict and trains both tables.
module pipe_branch_predictor #(
   parameter int         XLEN     = 32,
   parameter int         DEPTH    = 64,
   parameter logic [1:0] CTR_INIT = 2'b01,
   parameter int         CNT_W    = 16
) (
   input logic                  CLK,
   input logic                  RST_N,
   pipe_branch_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [1:0]       ctr_q   [DEPTH];
   logic             valid_q [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   logic [XLEN-1:0]  tgt_q   [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;

   assign if_idx = bus.if_pc[IDX_W+1:2];
   assign if_tag = bus.if_pc[XLEN-1:IDX_W+2];
   assign ex_idx = bus.ex_pc[IDX_W+1:2];
   assign ex_tag = bus.ex_pc[XLEN-1:IDX_W+2];

   // The lookup reads registered state only, so a same-cycle EX write is not seen until the next cycle.
   assign if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign bus.pred_taken  = if_hit && ctr_q[if_idx][1];
   assign bus.pred_target = bus.pred_taken ? tgt_q[if_idx] : bus.if_pc + XLEN'(4);

   logic cond, f3_legal, legal, mispredict;

   always_comb begin
      cond     = 1'b0;
      f3_legal = 1'b1;
      case (bus.ex_func3)
         3'b000:  cond = (bus.ex_rs1 == bus.ex_rs2);
         3'b001:  cond = (bus.ex_rs1 != bus.ex_rs2);
         3'b100:  cond = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
         3'b101:  cond = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
         3'b110:  cond = (bus.ex_rs1 <  bus.ex_rs2);
         3'b111:  cond = (bus.ex_rs1 >= bus.ex_rs2);
         default: f3_legal = 1'b0;
      endcase
   end

   assign legal      = bus.ex_branch_en && f3_legal;
   assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign mispredict = legal && ((cond != bus.ex_pred_taken) ||
                                 (cond && (bus.ex_pred_target != bus.ex_target)));

   assign bus.ex_taken       = legal && cond;
   assign bus.ex_mispredict  = mispredict;
   assign bus.ex_redirect_pc = !bus.ex_branch_en ? '0 :
                               (bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4));

   // The count stops at its maximum value and does not wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (mispredict && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   assign bus.mispredict_cnt = cnt_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_q[i]   <= CTR_INIT;
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
         end
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (legal) begin
            if (ex_hit) begin
               if (cond) begin
                  if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                  tgt_q[ex_idx] <= bus.ex_target;
               end else if (ctr_q[ex_idx] != 2'b00) begin
                  ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
               end
            end else if (cond) begin
               // A taken branch that misses claims the slot and starts out weakly taken.
               valid_q[ex_idx] <= 1'b1;
               tag_q[ex_idx]   <= ex_tag;
               tgt_q[ex_idx]   <= bus.ex_target;
               ctr_q[ex_idx]   <= 2'b10;
            end
         end
      end
   end
endmodule

// File: tb/tb_pipe_branch_predictor.sv
// Directed bench for pipe_branch_predictor: a table of resolve vectors followed by
// hand-written training, aliasing, counter-saturation and async-reset sequences.
module tb_pipe_branch_predictor;
  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int CNT_W = 4;

  logic CLK;
  logic RST_N;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_branch_predictor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus();

  pipe_branch_predictor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .CTR_INIT(2'b01), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.ex_branch_en   = 1'b0;
    bus.ex_func3       = 3'b000;
    bus.ex_rs1         = '0;
    bus.ex_rs2         = '0;
    bus.ex_pc          = '0;
    bus.ex_target      = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;
  endtask

  task automatic drive_ex(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
    bus.ex_branch_en   = 1'b1;
    bus.ex_func3       = f3;
    bus.ex_rs1         = rs1;
    bus.ex_rs2         = rs2;
    bus.ex_pc          = pc;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
  endtask

  // One resolved branch held for one cycle, then EX goes idle again.
  task automatic resolve(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
    @(negedge CLK);
    drive_ex(3'b000, 32'd7, taken ? 32'd7 : 32'd8, pc, tgt, 1'b0, pc + 32'd4);
    @(posedge CLK);
    @(negedge CLK);
    idle();
  endtask

  task automatic check_pred(input string name, input logic [31:0] pc,
                            input logic exp_t, input logic [31:0] exp_tgt);
    bus.if_pc = pc;
    #1;
    chk({name, ".pred_taken"}, 32'(bus.pred_taken), 32'(exp_t));
    chk({name, ".pred_target"}, bus.pred_target, exp_tgt);
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken, e_misp;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs[11];

  initial begin
    //            en  f3    rs1           rs2           pc            tgt           pt  ptgt          tk  mp  redirect
    vecs[0]  = '{1'b1, 3'd0, 32'd5,        32'd5,        32'h100,      32'h80,       1'b0, 32'h104,  1'b1, 1'b1, 32'h80};
    vecs[1]  = '{1'b1, 3'd1, 32'd5,        32'd5,        32'h100,      32'h80,       1'b0, 32'h104,  1'b0, 1'b0, 32'h104};
    vecs[2]  = '{1'b1, 3'd4, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h240,      1'b1, 32'h240,  1'b1, 1'b0, 32'h240};
    vecs[3]  = '{1'b1, 3'd6, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h240,      1'b1, 32'h240,  1'b0, 1'b1, 32'h204};
    vecs[4]  = '{1'b1, 3'd5, 32'd1,        32'hFFFFFFFF, 32'h300,      32'h380,      1'b1, 32'h390,  1'b1, 1'b1, 32'h380};
    vecs[5]  = '{1'b1, 3'd7, 32'd1,        32'hFFFFFFFF, 32'h300,      32'h380,      1'b0, 32'h304,  1'b0, 1'b0, 32'h304};
    vecs[6]  = '{1'b1, 3'd2, 32'd5,        32'd5,        32'h400,      32'h480,      1'b1, 32'h480,  1'b0, 1'b0, 32'h404};
    vecs[7]  = '{1'b0, 3'd0, 32'd5,        32'd5,        32'h400,      32'h480,      1'b0, 32'h404,  1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 3'd1, 32'd3,        32'd4,        32'h500,      32'h520,      1'b1, 32'h520,  1'b1, 1'b0, 32'h520};
    vecs[9]  = '{1'b1, 3'd0, 32'd1,        32'd2,        32'hFFFFFFFC, 32'h10,       1'b1, 32'h10,   1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 3'd3, 32'd0,        32'd0,        32'h600,      32'h0,        1'b0, 32'h604,  1'b0, 1'b0, 32'h604};

    bus.if_pc = 32'h100;
    idle();
    do_reset();

    // reset state
    check_pred("reset", 32'h100, 1'b0, 32'h104);
    chk("reset.cnt", 32'(bus.mispredict_cnt), 32'd0);

    // resolve table
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      drive_ex(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].tgt,
               vecs[i].pt, vecs[i].ptgt);
      bus.ex_branch_en = vecs[i].en;
      #1;
      chk($sformatf("vec%0d.taken", i), 32'(bus.ex_taken), 32'(vecs[i].e_taken));
      chk($sformatf("vec%0d.misp", i), 32'(bus.ex_mispredict), 32'(vecs[i].e_misp));
      chk($sformatf("vec%0d.redirect", i), bus.ex_redirect_pc, vecs[i].e_redir);
      @(posedge CLK);
    end
    @(negedge CLK);
    idle();
    #1;
    chk("table.cnt", 32'(bus.mispredict_cnt), 32'd4);

    do_reset();

    // first taken BEQ allocates; same-cycle lookup still sees the old entry
    @(negedge CLK);
    drive_ex(3'b000, 32'd5, 32'd5, 32'h100, 32'h80, 1'b0, 32'h104);
    bus.if_pc = 32'h100;
    #1;
    chk("alloc.misp", 32'(bus.ex_mispredict), 32'd1);
    chk("alloc.redirect", bus.ex_redirect_pc, 32'h80);
    chk("alloc.same_cycle_pred", 32'(bus.pred_taken), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    idle();
    check_pred("alloc.next", 32'h100, 1'b1, 32'h80);
    chk("alloc.cnt", 32'(bus.mispredict_cnt), 32'd1);

    // counter walk 2 -> 3 -> 3 -> 2 -> 1 -> 2, target refreshed on taken hits
    resolve(1'b1, 32'h100, 32'h80);
    resolve(1'b1, 32'h100, 32'h90);
    check_pred("sat3", 32'h100, 1'b1, 32'h90);
    resolve(1'b0, 32'h100, 32'h90);
    check_pred("ctr2", 32'h100, 1'b1, 32'h90);
    resolve(1'b0, 32'h100, 32'h90);
    check_pred("ctr1", 32'h100, 1'b0, 32'h104);
    resolve(1'b1, 32'h100, 32'hA0);
    check_pred("ctr2b", 32'h100, 1'b1, 32'hA0);

    // aliasing: 0x100 + 4*DEPTH shares index 0 with 0x100
    resolve(1'b1, 32'h100 + 32'(4 * DEPTH), 32'h700);
    check_pred("alias.evicted", 32'h100, 1'b0, 32'h104);
    check_pred("alias.new", 32'h100 + 32'(4 * DEPTH), 1'b1, 32'h700);
    resolve(1'b0, 32'h300, 32'h0);
    check_pred("alias.nt_miss_keeps", 32'h100 + 32'(4 * DEPTH), 1'b1, 32'h700);
    check_pred("alias.nt_miss_noalloc", 32'h300, 1'b0, 32'h304);

    // mispredict counter saturation at 2^CNT_W-1
    do_reset();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      resolve(1'b1, 32'h400, 32'h440);
      if (i == 14) chk("cnt.at15", 32'(bus.mispredict_cnt), 32'd15);
    end
    chk("cnt.saturated", 32'(bus.mispredict_cnt), 32'd15);
    check_pred("pre_reset", 32'h400, 1'b1, 32'h440);

    // async reset in the middle of a cycle with a training update pending
    @(negedge CLK);
    drive_ex(3'b000, 32'd1, 32'd1, 32'h400, 32'h440, 1'b0, 32'h404);
    #1;
    RST_N = 1'b0;
    #1;
    chk("async.cnt", 32'(bus.mispredict_cnt), 32'd0);
    chk("async.pred_taken", 32'(bus.pred_taken), 32'd0);
    chk("async.pred_target", bus.pred_target, 32'h404);
    @(posedge CLK);
    @(negedge CLK);
    idle();
    RST_N = 1'b1;
    check_pred("after_reset", 32'h400, 1'b0, 32'h404);
    chk("after_reset.cnt", 32'(bus.mispredict_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end
endmodule
